teclado_scanner: RTL and testbench
==================================

// Module: teclado_scanner
// PURPOSE
//  4x4 matrix keypad scanner/encoder: the producer side of the calculator key-event interface.
//  Drives columns, samples rows, debounces, and emits one key event per physical press.
//  Each event is a 4-bit key code plus 1-cycle strobes (digit_en, operando_en, igual_en).
//  The operation FSM and the number-entry logic consume these strobes.
// PARAMETERS
//  SCAN_DIV      1000  clk cycles per column dwell and per debounce sample (>=4)
//  DEBOUNCE_CNT  8     consecutive equal samples needed to accept a press or a release (>=2)
// PORTS
//  clk          in   1  system clock, single clock domain
//  reset        in   1  asynchronous, active-low reset
//  row_in       in   4  keypad rows, active-low, pulled up externally, asynchronous
//  col_out      out  4  keypad columns, active-low, exactly one bit low at any time
//  key_code     out  4  code of the last accepted key; held until the next event
//  key_valid    out  1  1-cycle pulse per accepted press
//  digit_en     out  1  1-cycle pulse, coincident with key_valid, when key_code is 0-9
//  operando_en  out  1  1-cycle pulse, coincident with key_valid, when key_code is 10 or 11
//  igual_en     out  1  1-cycle pulse, coincident with key_valid, when key_code is 15
//  key_held     out  1  high from the EMIT cycle until the release is debounced
// BEHAVIOUR
//  Reset (async assert, sync deassert):
//   - col_out=4'b1110, key_code=0, and all strobes and key_held are 0.
//   - The FSM enters SCAN, the column index is 0, and all counters are 0.
//   - Asserting reset mid-operation aborts any press in progress; no strobe is emitted.
//  row_in passes through a 2-FF synchronizer. All decisions use the synchronized value rs.
//  A sample tick occurs on the last cycle of each SCAN_DIV dwell (divider wraps at SCAN_DIV-1).
//  Key map (row r, col c), codes row-major:
//   - row 0: 1  2  3  10(+)
//   - row 1: 4  5  6  11(-)
//   - row 2: 7  8  9  12
//   - row 3: 14 0  15(=) 13
//  FSM states:
//   - SCAN: on each tick, if rs==4'hF, advance the column index (3 wraps to 0).
//     Otherwise, latch the column and rs, freeze the column, clear the counter, and go to DEBOUNCE.
//   - DEBOUNCE: on each tick, if rs equals the latched pattern, increment the counter.
//     When the count reaches DEBOUNCE_CNT, go to EMIT.
//     On a mismatch, go to SCAN; scanning resumes at the next column.
//   - EMIT: lasts exactly one cycle. Register key_code and pulse key_valid plus the matching class strobe.
//     Codes 12, 13 and 14 pulse key_valid only. Then go to HELD.
//   - HELD: the column stays frozen. Each tick with rs==4'hF increments the counter; any other rs clears it.
//     When the count reaches DEBOUNCE_CNT, key_held drops and the FSM goes to SCAN at the next column.
//  Several rows low at once: the lowest-index low row wins. Other columns are not examined while frozen.
//  A second key pressed during HELD is ignored; no auto-repeat.
//  Press latency: a stable press is accepted within one full scan (4*SCAN_DIV cycles).
//   - key_valid then rises 2 + DEBOUNCE_CNT*SCAN_DIV (+1 for EMIT) cycles later.
//  Strobes are registered outputs and are never asserted for two consecutive cycles.
// STRUCTURE
//  Shared package calc_pkg:
//   - key-code constants KEY_SUMA=4'd10, KEY_RESTA=4'd11, KEY_IGUAL=4'd15
//   - scanner state encoding: SCAN, DEBOUNCE, EMIT, HELD
//   - 16-entry key-map table
//  Sub-module sync_2ff (4-bit wide), instantiated once on row_in.
//  Top level contains the divider, the column ring, the FSM, the debounce counter and the output registers.
// TESTING (SCAN_DIV=4, DEBOUNCE_CNT=3, behavioural keypad model)
//  1. Press r1c1 (key 5) held 200 cycles -> exactly one key_valid with key_code=5 and digit_en=1.
//     operando_en and igual_en stay 0; key_held stays high until 12+ cycles after release.
//  2. Press r0c3 (+) -> key_code=10, operando_en=1. Then r3c2 (=) -> key_code=15, igual_en=1.
//     Then r1c3 (-) -> key_code=11, operando_en=1.
//  3. Bouncy press r2c0 toggling every 3 cycles for 40 cycles, then stable -> one event, key_code=7.
//     Bouncy release produces no second event.
//  4. Glitch: row 0 low for 5 cycles only -> the FSM leaves DEBOUNCE for SCAN and emits no strobe.
//     col_out resumes rotating from the next column.
//  5. Hold r3c1 (0), then also press r0c0 -> only key 0 is reported.
//     Release both -> the scan restarts; pressing r0c0 alone then yields key_code=1.
//  6. Assert reset during DEBOUNCE and during HELD -> outputs take reset values immediately.
//     No strobe is emitted; after release, col_out=1110 and scanning restarts.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator definitions: key codes, keypad scanner states and the 4x4 key map.
package calc_pkg;

   localparam logic [3:0] KEY_SUMA  = 4'd10;
   localparam logic [3:0] KEY_RESTA = 4'd11;
   localparam logic [3:0] KEY_IGUAL = 4'd15;

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      EMIT,
      HELD
   } scan_state_e;

   // Indexed by {row, col}; entry 0 is row 0 / col 0.
   localparam logic [15:0][3:0] KEY_MAP = {
      4'd13, 4'd15, 4'd0,  4'd14,
      4'd12, 4'd9,  4'd8,  4'd7,
      4'd11, 4'd6,  4'd5,  4'd4,
      4'd10, 4'd3,  4'd2,  4'd1
   };

   // Lowest-index active-low row wins when several rows are pressed together.
   function automatic logic [1:0] low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd3;
      if (!rows[2]) idx = 2'd2;
      if (!rows[1]) idx = 2'd1;
      if (!rows[0]) idx = 2'd0;
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; each bit is synchronized independently.
module sync_2ff #(
   parameter int unsigned      Width    = 4,
   parameter logic [Width-1:0] ResetVal = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [Width-1:0] d_i,
   output logic [Width-1:0] q_o
);

   logic [Width-1:0] meta_q;
   logic [Width-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= ResetVal;
         sync_q <= ResetVal;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/teclado_scanner.sv
// 4x4 keypad scanner: rotates active-low columns, debounces the rows and emits one
// key event (code plus class strobes) per physical press.
module teclado_scanner
   import calc_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 1000,
   parameter int unsigned DEBOUNCE_CNT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       digit_en,
   output logic       operando_en,
   output logic       igual_en,
   output logic       key_held
);

   localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CntW = $clog2(DEBOUNCE_CNT + 1);

   // Reset asserts asynchronously and is released on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n = rst_sync_q[1];

   logic [3:0] rs;

   sync_2ff #(
      .Width    (4),
      .ResetVal (4'hF)
   ) u_row_sync (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .d_i    (row_in),
      .q_o    (rs)
   );

   scan_state_e     state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic [1:0]      col_q, col_d;
   logic [3:0]      pat_q, pat_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] cnt_inc;
   logic [3:0]      key_code_q, key_code_d;
   logic            valid_q, valid_d;
   logic            digit_q, digit_d;
   logic            oper_q, oper_d;
   logic            igual_q, igual_d;
   logic            held_q, held_d;
   logic            tick;
   logic            cnt_done;
   logic [3:0]      emit_code;

   assign tick      = (div_q == DivW'(SCAN_DIV - 1));
   assign div_d     = tick ? '0 : div_q + 1'b1;
   assign cnt_inc   = cnt_q + 1'b1;
   assign cnt_done  = (cnt_inc == CntW'(DEBOUNCE_CNT));
   assign emit_code = KEY_MAP[{low_row(pat_q), col_q}];

   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      pat_d      = pat_q;
      cnt_d      = cnt_q;
      key_code_d = key_code_q;
      valid_d    = 1'b0;
      digit_d    = 1'b0;
      oper_d     = 1'b0;
      igual_d    = 1'b0;
      held_d     = held_q;

      case (state_q)
         SCAN: begin
            if (tick) begin
               if (rs == 4'hF) begin
                  col_d = col_q + 2'd1;
               end else begin
                  pat_d   = rs;
                  cnt_d   = '0;
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (rs == pat_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_done) state_d = EMIT;
               end else begin
                  col_d   = col_q + 2'd1;
                  state_d = SCAN;
               end
            end
         end
         EMIT: begin
            key_code_d = emit_code;
            valid_d    = 1'b1;
            digit_d    = (emit_code <= 4'd9);
            oper_d     = (emit_code == KEY_SUMA) || (emit_code == KEY_RESTA);
            igual_d    = (emit_code == KEY_IGUAL);
            held_d     = 1'b1;
            cnt_d      = '0;
            state_d    = HELD;
         end
         HELD: begin
            // Release must be seen on DEBOUNCE_CNT consecutive ticks; any low row restarts it.
            if (tick) begin
               if (rs == 4'hF) begin
                  cnt_d = cnt_inc;
                  if (cnt_done) begin
                     cnt_d   = '0;
                     held_d  = 1'b0;
                     col_d   = col_q + 2'd1;
                     state_d = SCAN;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SCAN;
         div_q      <= '0;
         col_q      <= 2'd0;
         pat_q      <= 4'hF;
         cnt_q      <= '0;
         key_code_q <= 4'd0;
         valid_q    <= 1'b0;
         digit_q    <= 1'b0;
         oper_q     <= 1'b0;
         igual_q    <= 1'b0;
         held_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         col_q      <= col_d;
         pat_q      <= pat_d;
         cnt_q      <= cnt_d;
         key_code_q <= key_code_d;
         valid_q    <= valid_d;
         digit_q    <= digit_d;
         oper_q     <= oper_d;
         igual_q    <= igual_d;
         held_q     <= held_d;
      end
   end

   assign col_out     = ~(4'b0001 << col_q);
   assign key_code    = key_code_q;
   assign key_valid   = valid_q;
   assign digit_en    = digit_q;
   assign operando_en = oper_q;
   assign igual_en    = igual_q;
   assign key_held    = held_q;

endmodule

// File: tb/tb_teclado_scanner.sv
// Bench for teclado_scanner: behavioural keypad model plus an event scoreboard.
module tb_teclado_scanner;

   localparam int unsigned SCAN_DIV     = 4;
   localparam int unsigned DEBOUNCE_CNT = 3;
   // Press applied as its column arrives: one dwell to the latching tick, the debounce
   // ticks, then the EMIT cycle.
   localparam int LAT = SCAN_DIV + DEBOUNCE_CNT * SCAN_DIV + 1;
   localparam int KMAP [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

   typedef struct packed {
      logic [3:0] code;
      logic       dig;
      logic       opr;
      logic       igu;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       digit_en;
   logic       operando_en;
   logic       igual_en;
   logic       key_held;

   logic [15:0] key_down;
   logic        glitch_en;
   ev_t         exp_q[$];
   ev_t         obs_q[$];
   int          n_checks = 0;
   int          n_pass   = 0;
   int          strobe_err = 0;
   logic        prev_valid = 1'b0;

   teclado_scanner #(
      .SCAN_DIV     (SCAN_DIV),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .row_in      (row_in),
      .col_out     (col_out),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .digit_en    (digit_en),
      .operando_en (operando_en),
      .igual_en    (igual_en),
      .key_held    (key_held)
   );

   always #5 clk = ~clk;

   // Keypad: a pressed key shorts its row to its column while that column is driven low.
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (key_down[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
      if (glitch_en) row_in[0] = 1'b0;
   end

   always @(negedge clk) begin
      ev_t e;
      if (key_valid) begin
         e.code = key_code;
         e.dig  = digit_en;
         e.opr  = operando_en;
         e.igu  = igual_en;
         obs_q.push_back(e);
      end
      if ((digit_en || operando_en || igual_en) && !key_valid) strobe_err++;
      if (key_valid && prev_valid) strobe_err++;
      prev_valid = key_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1);
   end

   function automatic ev_t exp_ev(input int code);
      ev_t e;
      e.code = 4'(code);
      e.dig  = (code <= 9);
      e.opr  = (code == 10) || (code == 11);
      e.igu  = (code == 15);
      return e;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on the negedge just after column c becomes active.
   task automatic wait_col(input int c);
      logic [3:0] want;
      logic [3:0] last;
      bit         found;
      want  = 4'b0001 << c;
      want  = ~want;
      last  = col_out;
      found = 1'b0;
      for (int i = 0; i < 64 && !found; i++) begin
         @(negedge clk);
         if (col_out == want && last != want) found = 1'b1;
         last = col_out;
      end
      n_checks++;
      if (!found) $display("FAIL wait_col: column %0d never arrived, col_out=%b", c, col_out);
      else n_pass++;
   endtask

   task automatic wait_obs(input int budget);
      for (int i = 0; i < budget && obs_q.size() == 0; i++) @(negedge clk);
   endtask

   task automatic wait_release(input int budget);
      for (int i = 0; i < budget && key_held; i++) @(negedge clk);
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      key_down  = '0;
      glitch_en = 1'b0;
      wait_cycles(4);
      n_checks++;
      if (col_out !== 4'b1110 || key_code !== 4'd0) begin
         $display("FAIL reset_regs: col_out=%b key_code=%0d, want 1110 and 0", col_out, key_code);
      end else n_pass++;
      n_checks++;
      if ({key_valid, digit_en, operando_en, igual_en, key_held} !== 5'b0) begin
         $display("FAIL reset_strobes: v/d/o/i/h=%b, want 00000",
                  {key_valid, digit_en, operando_en, igual_en, key_held});
      end else n_pass++;
      reset = 1'b1;
      wait_cycles(4);
   endtask

   task automatic test_key5();
      ev_t got, want;
      int  lat;
      wait_col(1);
      key_down[5] = 1'b1;
      exp_q.push_back(exp_ev(KMAP[5]));
      lat = 0;
      for (int i = 1; i <= 80 && lat == 0; i++) begin
         @(negedge clk);
         if (key_valid) lat = i;
      end
      n_checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin
         $display("FAIL key5_latency: got %0d cycles, want %0d", lat, LAT);
      end else n_pass++;
      wait_obs(4);
      want = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL key5_event: no event, want code %0d", want.code);
      else begin
         got = obs_q.pop_front();
         if (got !== want) $display("FAIL key5_event: got %h, want %h (code,d,o,i)", got, want);
         else n_pass++;
      end
      wait_cycles(200 - lat);
      n_checks++;
      if (!key_held || obs_q.size() != 0) begin
         $display("FAIL key5_hold: key_held=%b extra events=%0d, want 1 and 0", key_held,
                  obs_q.size());
      end else n_pass++;
      key_down = '0;
      wait_cycles(8);
      n_checks++;
      if (key_held !== 1'b1) $display("FAIL key5_held_early: key_held=%b, want 1", key_held);
      else n_pass++;
      wait_release(40);
      n_checks++;
      if (key_held !== 1'b0 || obs_q.size() != 0) begin
         $display("FAIL key5_release: key_held=%b events=%0d, want 0 and 0", key_held,
                  obs_q.size());
      end else n_pass++;
   endtask

   task automatic test_classes();
      logic [15:0] masks [4];
      int          codes [4];
      ev_t         got, want;
      masks = '{16'h0008, 16'h4000, 16'h0080, 16'h0101};
      codes = '{10, 15, 11, 1};
      for (int k = 0; k < 4; k++) begin
         wait_cycles(8);
         key_down = masks[k];
         exp_q.push_back(exp_ev(codes[k]));
         wait_obs(80);
         want = exp_q.pop_front();
         n_checks++;
         if (obs_q.size() == 0) $display("FAIL class_event%0d: no event, want code %0d", k,
                                         want.code);
         else begin
            got = obs_q.pop_front();
            if (got !== want) $display("FAIL class_event%0d: got %h, want %h (code,d,o,i)", k,
                                       got, want);
            else n_pass++;
         end
         key_down = '0;
         wait_release(40);
      end
      n_checks++;
      if (key_held !== 1'b0) $display("FAIL class_release: key_held=%b, want 0", key_held);
      else n_pass++;
   endtask

   task automatic test_bounce();
      ev_t got, want;
      exp_q.push_back(exp_ev(KMAP[8]));
      for (int i = 0; i < 40; i++) begin
         key_down[8] = ((i / 3) % 2 == 0);
         @(negedge clk);
      end
      key_down[8] = 1'b1;
      wait_obs(80);
      want = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL bounce_event: no event, want code %0d", want.code);
      else begin
         got = obs_q.pop_front();
         if (got !== want) $display("FAIL bounce_event: got %h, want %h (code,d,o,i)", got,
                                    want);
         else n_pass++;
      end
      wait_cycles(30);
      for (int i = 0; i < 40; i++) begin
         key_down[8] = ((i / 3) % 2 != 0);
         @(negedge clk);
      end
      key_down = '0;
      wait_cycles(60);
      n_checks++;
      if (obs_q.size() != 0 || key_held !== 1'b0) begin
         $display("FAIL bounce_release: extra events=%0d key_held=%b, want 0 and 0",
                  obs_q.size(), key_held);
      end else n_pass++;
   endtask

   task automatic test_glitch();
      logic [3:0] cur;
      int         dwell, first_dwell, n_trans, rot_err;
      wait_col(0);
      glitch_en   = 1'b1;
      cur         = col_out;
      dwell       = 1;
      first_dwell = 0;
      n_trans     = 0;
      rot_err     = 0;
      for (int i = 1; i <= 48; i++) begin
         @(negedge clk);
         if (i == 5) glitch_en = 1'b0;
         if (col_out == cur) dwell++;
         else begin
            if (col_out !== {cur[2:0], cur[3]}) rot_err++;
            if (n_trans == 0) first_dwell = dwell;
            n_trans++;
            cur   = col_out;
            dwell = 1;
         end
      end
      n_checks++;
      if (obs_q.size() != 0) $display("FAIL glitch_event: events=%0d, want 0", obs_q.size());
      else n_pass++;
      n_checks++;
      if (first_dwell != 2 * SCAN_DIV) begin
         $display("FAIL glitch_freeze: frozen dwell=%0d, want %0d", first_dwell, 2 * SCAN_DIV);
      end else n_pass++;
      n_checks++;
      if (rot_err != 0 || n_trans < 4) begin
         $display("FAIL glitch_rotate: bad steps=%0d steps=%0d, want 0 and >=4", rot_err,
                  n_trans);
      end else n_pass++;
   endtask

   task automatic test_hold_two();
      ev_t got, want;
      key_down[13] = 1'b1;
      exp_q.push_back(exp_ev(KMAP[13]));
      wait_obs(80);
      want = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL hold0_event: no event, want code %0d", want.code);
      else begin
         got = obs_q.pop_front();
         if (got !== want) $display("FAIL hold0_event: got %h, want %h (code,d,o,i)", got,
                                    want);
         else n_pass++;
      end
      key_down[0] = 1'b1;
      wait_cycles(60);
      n_checks++;
      if (obs_q.size() != 0 || key_held !== 1'b1) begin
         $display("FAIL hold_second_key: events=%0d key_held=%b, want 0 and 1", obs_q.size(),
                  key_held);
      end else n_pass++;
      key_down = '0;
      wait_release(40);
      wait_cycles(8);
      key_down[0] = 1'b1;
      exp_q.push_back(exp_ev(KMAP[0]));
      wait_obs(80);
      want = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL hold1_event: no event, want code %0d", want.code);
      else begin
         got = obs_q.pop_front();
         if (got !== want) $display("FAIL hold1_event: got %h, want %h (code,d,o,i)", got,
                                    want);
         else n_pass++;
      end
      key_down = '0;
      wait_release(40);
      wait_cycles(8);
   endtask

   task automatic test_reset_mid();
      ev_t got, want;
      // Abort during DEBOUNCE on column 2, so the frozen column differs from the reset one.
      wait_col(2);
      key_down[2] = 1'b1;
      wait_cycles(6);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (col_out !== 4'b1110 || key_code !== 4'd0 ||
          {key_valid, digit_en, operando_en, igual_en, key_held} !== 5'b0) begin
         $display("FAIL reset_debounce: col_out=%b key_code=%0d v/d/o/i/h=%b, want 1110 0 00000",
                  col_out, key_code, {key_valid, digit_en, operando_en, igual_en, key_held});
      end else n_pass++;
      key_down = '0;
      wait_cycles(3);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if (col_out !== 4'b1110) $display("FAIL reset_restart: col_out=%b, want 1110", col_out);
      else n_pass++;
      wait_cycles(40);
      n_checks++;
      if (obs_q.size() != 0) $display("FAIL reset_debounce_event: events=%0d, want 0",
                                      obs_q.size());
      else n_pass++;

      wait_col(1);
      key_down[5] = 1'b1;
      exp_q.push_back(exp_ev(KMAP[5]));
      wait_obs(80);
      want = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL rheld_event: no event, want code %0d", want.code);
      else begin
         got = obs_q.pop_front();
         if (got !== want) $display("FAIL rheld_event: got %h, want %h (code,d,o,i)", got,
                                    want);
         else n_pass++;
      end
      wait_cycles(5);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (key_held !== 1'b0 || key_code !== 4'd0 || col_out !== 4'b1110) begin
         $display("FAIL reset_held: key_held=%b key_code=%0d col_out=%b, want 0 0 1110",
                  key_held, key_code, col_out);
      end else n_pass++;
      key_down = '0;
      wait_cycles(3);
      reset = 1'b1;
      wait_cycles(40);
      n_checks++;
      if (obs_q.size() != 0 || exp_q.size() != 0 || strobe_err != 0) begin
         $display("FAIL final_scoreboard: extra=%0d pending=%0d strobe_err=%0d, want 0 0 0",
                  obs_q.size(), exp_q.size(), strobe_err);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_key5();
      test_classes();
      test_bounce();
      test_glitch();
      test_hold_two();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
